cnn_layer_accel_macc_seq: RTL and testbench
===========================================

CNN_LAYER_ACCEL_MACC_SEQ -- requirements
Module: cnn_layer_accel_macc_seq

Interface
REQ-001 SHALL have parameter C_DSP_OUTPUT_WIDTH, default 48: width of the accumulating DSP's pout.
REQ-002 SHALL have parameter C_ACC_LATENCY, default 2: cycles from an accepted beat to the cycle its accum strobe is driven (input delay plus multiply register plus chain skew).
REQ-003 SHALL have parameter C_FRAC_SHIFT, default 8: arithmetic right shift applied to each window sum.
REQ-004 SHALL have parameter C_RESULT_WIDTH, default 16: signed result width.
REQ-005 SHALL have parameter C_OUT_DEPTH, default 2: result buffer entries, which is also the window credit count.
REQ-006 SHALL have port clk, input, 1: clock.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-high; the same rst drives the DSP chain.
REQ-008 SHALL have port op_valid, input, 1: an operand beat is presented to the chain this cycle.
REQ-009 SHALL have port op_last, input, 1: the beat closes the current window.
REQ-010 SHALL have port op_ready, output, 1: a beat is accepted when op_valid and op_ready are both high.
REQ-011 SHALL have port accum, output, 1: drives the accum input of the accumulating DSP.
REQ-012 SHALL have port pout, input, C_DSP_OUTPUT_WIDTH: running sum from the accumulating DSP.
REQ-013 SHALL have port res_valid, output, 1: a result is presented.
REQ-014 SHALL have port res_ready, input, 1: the consumer accepts the result.
REQ-015 SHALL have port res_data, output, C_RESULT_WIDTH: signed window result.
REQ-016 SHALL have port res_sat, output, 1: res_data was saturated.
REQ-017 SHALL have port busy, output, 1: a beat or capture is in flight, or the buffer is non-empty.

Function
REQ-018 SHALL delay each accepted beat's valid and last flags by exactly C_ACC_LATENCY cycles, and drive accum high only in the delayed-valid cycle.
REQ-019 SHALL never drive accum for a beat that was offered but not accepted.
REQ-020 SHALL, in the cycle after a delayed-last accum, register diff = pout - base as modulo-2^C_DSP_OUTPUT_WIDTH subtraction, and set base to pout in the same cycle.
REQ-021 SHALL treat diff as signed, shift it arithmetically right by C_FRAC_SHIFT (truncating toward minus infinity), and saturate to the C_RESULT_WIDTH signed range.
REQ-022 SHALL set res_sat=1 for that entry whenever clamping occurred.
REQ-023 SHALL push the result into the buffer one cycle after diff is registered.
REQ-024 SHALL give a fixed latency: op_last accepted in cycle c gives res_valid high in cycle c+C_ACC_LATENCY+3 when the buffer is empty.
REQ-025 SHALL support back-to-back windows with no idle cycle; the next window's first accum SHALL NOT corrupt the snapshot of the previous window.
REQ-026 SHALL keep a credit counter initialised to C_OUT_DEPTH: decremented on accepted op_last, incremented on a result pop, applied together when both occur in the same cycle.
REQ-027 SHALL drive op_ready = (credits != 0).
REQ-028 SHALL implement the buffer as a FIFO; res_data and res_sat SHALL be stable while res_valid=1 and res_ready=0.
REQ-029 SHALL allow a simultaneous push and pop when the FIFO is full or empty without loss or duplication.
REQ-030 SHALL have a capture FSM with states IDLE, SNAP and PUSH:
- IDLE→SNAP on delayed-last accum.
- SNAP→PUSH unconditionally.
- PUSH→SNAP if another delayed-last accum occurs in this cycle, else PUSH→IDLE.

Reset
REQ-031 SHALL, on rst, clear all of the following:
- the delay line
- the FSM (to IDLE)
- base=0
- the FIFO (to empty)
- credits=C_OUT_DEPTH
REQ-032 SHALL hold these output values during and immediately after reset: accum=0, res_valid=0, res_data=0, res_sat=0, busy=0, op_ready=1.
REQ-033 SHALL, on rst mid-window, discard the partial window and emit no result for it.

Structure
REQ-034 SHALL take the default widths, depth and FSM state encodings from the shared cnn_layer_accel package/header.
REQ-035 SHALL instantiate the result buffer as sub-module cnn_layer_accel_macc_res_fifo (parameterised by width and depth, with a valid/ready interface).

Verification
REQ-036 SHALL cover: window of 3 beats with products 256, 512, 768 (pout=1536) → res_data=6, res_sat=0, res_valid 5 cycles after op_last.
REQ-037 SHALL cover: window sum 2^24 → res_data=32767, res_sat=1; window sum -2^24 → res_data=-32768, res_sat=1.
REQ-038 SHALL cover: two back-to-back single-beat windows with products 256 and 1024 → results 1 then 4; accum high in two consecutive cycles.
REQ-039 SHALL cover: res_ready=0 with three windows offered → op_ready low after the 2nd op_last; one pop restores op_ready, and results arrive in order.
REQ-040 SHALL cover: base=2^48-256 and pout wraps to 512 → diff=768, res_data=3.
REQ-041 SHALL cover: rst asserted between the 2nd and 3rd beat of a window → no result, all outputs at reset values, and the next window's result is correct.

Source files
------------

// File: rtl/cnn_layer_accel_macc_seq_pkg.sv
// Shared defaults and capture-FSM encoding for the MACC sequencer.
// Also holds the sizing helpers used by the sequencer and its result FIFO.
package cnn_layer_accel_macc_seq_pkg;

    localparam int DSP_OUTPUT_WIDTH = 48;
    localparam int ACC_LATENCY      = 2;
    localparam int FRAC_SHIFT       = 8;
    localparam int RESULT_WIDTH     = 16;
    localparam int OUT_DEPTH        = 2;

    typedef enum logic [1:0] {
        CAP_IDLE = 2'd0,
        CAP_SNAP = 2'd1,
        CAP_PUSH = 2'd2
    } cap_state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int count_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    // Bits needed to address n entries.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cnn_layer_accel_macc_seq_if.sv
// Operand and result handshakes of the MACC sequencer.
// The master side feeds operand beats and consumes results.
interface cnn_layer_accel_macc_seq_if #(
    parameter int RESULT_WIDTH = cnn_layer_accel_macc_seq_pkg::RESULT_WIDTH
) ();

    logic                           op_valid;
    logic                           op_last;
    logic                           op_ready;
    logic                           res_valid;
    logic                           res_ready;
    logic signed [RESULT_WIDTH-1:0] res_data;
    logic                           res_sat;

    modport master (
        output op_valid,
        output op_last,
        input  op_ready,
        input  res_valid,
        output res_ready,
        input  res_data,
        input  res_sat
    );

    modport slave (
        input  op_valid,
        input  op_last,
        output op_ready,
        output res_valid,
        input  res_ready,
        output res_data,
        output res_sat
    );

endinterface

// File: rtl/cnn_layer_accel_macc_res_fifo.sv
// Result FIFO: array storage with a registered head stage so the output
// is a plain register; an empty FIFO bypasses the array straight to the head.
module cnn_layer_accel_macc_res_fifo
    import cnn_layer_accel_macc_seq_pkg::*;
#(
    parameter int WIDTH = RESULT_WIDTH + 1,
    parameter int DEPTH = OUT_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = count_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_reg;
    logic [PW-1:0]    rd_ptr_reg;
    logic [CW-1:0]    mem_count_reg;
    logic [CW-1:0]    count_reg;
    logic [WIDTH-1:0] head_reg;
    logic             head_valid_reg;

    logic push;
    logic pop;
    logic refill;
    logic from_mem;
    logic bypass;
    logic mem_wr;

    assign in_ready  = (count_reg < CW'(DEPTH));
    assign push      = in_valid && in_ready;
    assign pop       = head_valid_reg && out_ready;
    assign refill    = !head_valid_reg || pop;
    assign from_mem  = refill && (mem_count_reg != '0);
    assign bypass    = refill && (mem_count_reg == '0) && push;
    assign mem_wr    = push && !bypass;
    assign out_valid = head_valid_reg;
    assign out_data  = head_reg;

    // The array only holds entries behind a valid head, so a simultaneous
    // write and read never target the same slot.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[wr_ptr_reg] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg       <= '0;
            head_valid_reg <= 1'b0;
        end else if (from_mem) begin
            head_reg       <= mem[rd_ptr_reg];
            head_valid_reg <= 1'b1;
        end else if (bypass) begin
            head_reg       <= in_data;
            head_valid_reg <= 1'b1;
        end else if (pop) begin
            head_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            mem_count_reg <= '0;
            count_reg     <= '0;
        end else begin
            if (mem_wr) begin
                wr_ptr_reg <= (wr_ptr_reg == PW'(DEPTH - 1)) ? '0 : wr_ptr_reg + PW'(1);
            end
            if (from_mem) begin
                rd_ptr_reg <= (rd_ptr_reg == PW'(DEPTH - 1)) ? '0 : rd_ptr_reg + PW'(1);
            end
            if (mem_wr && !from_mem) begin
                mem_count_reg <= mem_count_reg + CW'(1);
            end else if (!mem_wr && from_mem) begin
                mem_count_reg <= mem_count_reg - CW'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CW'(1);
            end else if (!push && pop) begin
                count_reg <= count_reg - CW'(1);
            end
        end
    end

endmodule

// File: rtl/cnn_layer_accel_macc_seq.sv
// Sequences operand beats into an accumulating DSP, snapshots the running sum
// at each window end and queues the scaled, saturated window result.
module cnn_layer_accel_macc_seq
    import cnn_layer_accel_macc_seq_pkg::*;
#(
    parameter int C_DSP_OUTPUT_WIDTH = DSP_OUTPUT_WIDTH,
    parameter int C_ACC_LATENCY      = ACC_LATENCY,
    parameter int C_FRAC_SHIFT       = FRAC_SHIFT,
    parameter int C_RESULT_WIDTH     = RESULT_WIDTH,
    parameter int C_OUT_DEPTH        = OUT_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    cnn_layer_accel_macc_seq_if.slave     bus,
    output logic                          accum,
    input  logic [C_DSP_OUTPUT_WIDTH-1:0] pout,
    output logic                          busy
);

    localparam int W  = C_DSP_OUTPUT_WIDTH;
    localparam int R  = C_RESULT_WIDTH;
    localparam int L  = C_ACC_LATENCY;
    localparam int CW = count_width(C_OUT_DEPTH);

    localparam logic signed [W-1:0] RES_MAX = {{(W-R+1){1'b0}}, {(R-1){1'b1}}};
    localparam logic signed [W-1:0] RES_MIN = {{(W-R+1){1'b1}}, {(R-1){1'b0}}};

    logic [L-1:0]          vld_dly_reg;
    logic [L-1:0]          last_dly_reg;
    logic                  snap_reg;
    logic                  push_reg;
    logic signed [W-1:0]   diff_reg;
    logic [W-1:0]          base_reg;
    logic [CW-1:0]         credits_reg;
    logic [CW-1:0]         credits_next;
    cap_state_t            state_reg;
    cap_state_t            state_next;

    logic                  accept;
    logic                  last_take;
    logic                  last_accum;
    logic                  pop;
    logic signed [W-1:0]   shifted;
    logic                  sat_hi;
    logic                  sat_lo;
    logic [R-1:0]          res_word;
    logic                  fifo_in_ready;
    logic                  fifo_out_valid;
    logic [R:0]            fifo_out_data;

    assign accept     = bus.op_valid && bus.op_ready;
    assign last_take  = accept && bus.op_last;
    assign accum      = vld_dly_reg[L-1];
    assign last_accum = vld_dly_reg[L-1] && last_dly_reg[L-1];
    assign pop        = fifo_out_valid && bus.res_ready;

    // Only accepted beats enter the delay line, so a refused offer never
    // reaches the DSP accum input.
    for (genvar gi = 0; gi < L; gi++) begin : g_dly
        if (gi == 0) begin : g_head
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_dly_reg[gi]  <= 1'b0;
                    last_dly_reg[gi] <= 1'b0;
                end else begin
                    vld_dly_reg[gi]  <= accept;
                    last_dly_reg[gi] <= last_take;
                end
            end
        end else begin : g_tail
            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_dly_reg[gi]  <= 1'b0;
                    last_dly_reg[gi] <= 1'b0;
                end else begin
                    vld_dly_reg[gi]  <= vld_dly_reg[gi-1];
                    last_dly_reg[gi] <= last_dly_reg[gi-1];
                end
            end
        end
    end

    // Snapshot and push run as a two-stage pipe so back-to-back window ends
    // each get their own snapshot of pout one cycle after their accum.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap_reg <= 1'b0;
            push_reg <= 1'b0;
            diff_reg <= '0;
            base_reg <= '0;
        end else begin
            snap_reg <= last_accum;
            push_reg <= snap_reg;
            if (snap_reg) begin
                diff_reg <= pout - base_reg;
                base_reg <= pout;
            end
        end
    end

    assign shifted  = diff_reg >>> C_FRAC_SHIFT;
    assign sat_hi   = (shifted > RES_MAX);
    assign sat_lo   = (shifted < RES_MIN);
    assign res_word = sat_hi ? RES_MAX[R-1:0] : (sat_lo ? RES_MIN[R-1:0] : shifted[R-1:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CAP_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            CAP_IDLE: if (last_accum) state_next = CAP_SNAP;
            CAP_SNAP: state_next = CAP_PUSH;
            CAP_PUSH: state_next = last_accum ? CAP_SNAP : CAP_IDLE;
            default:  state_next = CAP_IDLE;
        endcase
    end

    // Each accepted window end reserves a FIFO slot, so the push never stalls.
    always_comb begin
        credits_next = credits_reg;
        if (last_take && !pop) begin
            credits_next = credits_reg - CW'(1);
        end else if (!last_take && pop) begin
            credits_next = credits_reg + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credits_reg <= CW'(C_OUT_DEPTH);
        end else begin
            credits_reg <= credits_next;
        end
    end

    assign bus.op_ready = (credits_reg != '0);

    cnn_layer_accel_macc_res_fifo #(
        .WIDTH (R + 1),
        .DEPTH (C_OUT_DEPTH)
    ) u_res_fifo (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (push_reg && fifo_in_ready),
        .in_ready  (fifo_in_ready),
        .in_data   ({(sat_hi || sat_lo), res_word}),
        .out_valid (fifo_out_valid),
        .out_ready (bus.res_ready),
        .out_data  (fifo_out_data)
    );

    assign bus.res_valid = fifo_out_valid;
    assign bus.res_data  = fifo_out_data[R-1:0];
    assign bus.res_sat   = fifo_out_data[R];

    assign busy = (|vld_dly_reg) || snap_reg || push_reg
                || (state_reg != CAP_IDLE) || fifo_out_valid;

endmodule

// File: tb/tb_cnn_layer_accel_macc_seq.sv
// Directed bench: a behavioural DSP accumulator feeds pout, a scoreboard queue
// holds expected window results and a negedge monitor checks each popped result.
module tb_cnn_layer_accel_macc_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        accum;
    logic        busy;
    logic [47:0] dsp_acc = '0;
    logic [47:0] cur_prod = '0;
    int          cyc = 0;
    int          n_assert = 0;
    int          n_fail = 0;
    int          run_len = 0;
    int          max_run = 0;
    bit          third_done = 1'b0;

    typedef struct {
        int data;
        bit sat;
        int t;
        int lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [47:0] prod_q[$];

    cnn_layer_accel_macc_seq_if #(.RESULT_WIDTH(16)) bus ();

    cnn_layer_accel_macc_seq dut (
        .clk   (clk),
        .rst   (rst),
        .bus   (bus),
        .accum (accum),
        .pout  (dsp_acc),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accumulating DSP model: each accum consumes the oldest accepted product.
    always @(posedge clk) begin
        if (rst) begin
            dsp_acc <= '0;
            prod_q.delete();
            run_len = 0;
        end else begin
            if (accum) begin
                check("accum_has_beat", longint'(prod_q.size() != 0), 1);
                if (prod_q.size() != 0) dsp_acc <= dsp_acc + prod_q.pop_front();
                run_len++;
                if (run_len > max_run) max_run = run_len;
            end else begin
                run_len = 0;
            end
            if (bus.op_valid && bus.op_ready) prod_q.push_back(cur_prod);
        end
    end

    logic        held = 1'b0;
    logic [15:0] held_data;
    logic        held_sat;

    always @(negedge clk) begin
        exp_t e;
        if (held) begin
            check("res_data_stable", bus.res_data, held_data);
            check("res_sat_stable", bus.res_sat, held_sat);
        end
        held      = bus.res_valid && !bus.res_ready;
        held_data = bus.res_data;
        held_sat  = bus.res_sat;
        if (bus.res_valid && bus.res_ready) begin
            $display("result data=%0d sat=%0d cycle=%0d", $signed(bus.res_data), bus.res_sat, cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("res_data", $signed(bus.res_data), e.data);
                check("res_sat", bus.res_sat, e.sat);
                if (e.lat >= 0) check("latency", cyc - e.t, e.lat);
            end
        end
    end

    task automatic send(input logic [47:0] prod, input bit last, input int exp_d,
                        input bit exp_s, input int exp_lat);
        int guard = 0;
        int t;
        while (!bus.op_ready) begin
            if (guard++ > 200) begin
                check("op_ready_wait", 0, 1);
                return;
            end
            @(posedge clk); #1;
        end
        bus.op_valid = 1'b1;
        bus.op_last  = last;
        cur_prod     = prod;
        t            = cyc;
        @(posedge clk); #1;
        bus.op_valid = 1'b0;
        bus.op_last  = 1'b0;
        if (last) exp_q.push_back('{exp_d, exp_s, t, exp_lat});
    endtask

    task automatic wait_idle();
        int guard = 0;
        while (busy || exp_q.size() != 0) begin
            if (guard++ > 100) begin
                check("idle_timeout", 0, 1);
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        rst          = 1'b1;
        bus.op_valid = 1'b0;
        bus.op_last  = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs_during",
              {accum, bus.res_valid, bus.res_data, bus.res_sat, busy, bus.op_ready}, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_outputs_after",
              {accum, bus.res_valid, bus.res_data, bus.res_sat, busy, bus.op_ready}, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.op_valid  = 1'b0;
        bus.op_last   = 1'b0;
        bus.res_ready = 1'b1;
        do_reset();

        // 3-beat window, sum 1536 -> 6, five cycles after op_last
        send(48'd256, 1'b0, 0, 1'b0, -1);
        send(48'd512, 1'b0, 0, 1'b0, -1);
        send(48'd768, 1'b1, 6, 1'b0, 5);
        wait_idle();

        // positive and negative saturation
        send(48'd16777216, 1'b1, 32767, 1'b1, 5);
        wait_idle();
        send(-48'sd16777216, 1'b1, -32768, 1'b1, 5);
        wait_idle();

        // back-to-back single-beat windows
        max_run = 0;
        send(48'd256, 1'b1, 1, 1'b0, 5);
        send(48'd1024, 1'b1, 4, 1'b0, 5);
        wait_idle();
        check("accum_consecutive", max_run, 2);

        // credit exhaustion with a stalled consumer
        bus.res_ready = 1'b0;
        send(48'd512, 1'b1, 2, 1'b0, -1);
        send(48'd768, 1'b1, 3, 1'b0, -1);
        check("op_ready_after_2nd_last", bus.op_ready, 0);
        third_done = 1'b0;
        fork
            begin
                send(48'd1280, 1'b1, 5, 1'b0, -1);
                third_done = 1'b1;
            end
        join_none
        repeat (10) begin @(posedge clk); #1; end
        check("op_ready_while_full", bus.op_ready, 0);
        check("third_blocked", third_done, 0);
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 20 && !third_done; i++) begin @(posedge clk); #1; end
        check("third_accepted", third_done, 1);
        repeat (8) begin @(posedge clk); #1; end
        bus.res_ready = 1'b1;
        wait_idle();

        // reset between 2nd and 3rd beat discards the window
        send(48'd256, 1'b0, 0, 1'b0, -1);
        send(48'd256, 1'b0, 0, 1'b0, -1);
        do_reset();
        repeat (8) begin @(posedge clk); #1; end
        check("no_result_after_rst", exp_q.size(), 0);

        // after reset: -256 -> -1, then pout wraps from 2^48-256 to 512
        send(48'hFFFF_FFFF_FF00, 1'b1, -1, 1'b0, 5);
        wait_idle();
        send(48'd768, 1'b1, 3, 1'b0, 5);
        wait_idle();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
